line_mem_ctrl: RTL

Line-wide backing-memory controller on the memory side of the data cache. Holds NUM_MEM_BYTES of storage organised as CACHE_LINE_SIZE-byte lines. Serves one full-line read or write per request over a valid/ready handshake with a fixed, parameterised access latency, so the cache's miss, refill and write-back paths see realistic multi-cycle memory timing. Single outstanding request; a one-cycle response pulse closes every transaction.

---
 rtl/line_mem_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/line_mem_ctrl.sv
// Line-wide backing memory for the data cache: one full-line read or write per
// request, committed a fixed LATENCY cycles after acceptance, closed by a one-cycle response.
module line_mem_ctrl #(
    parameter int CACHE_LINE_SIZE = 16,
    parameter int NUM_MEM_BYTES   = 1024,
    parameter int LATENCY         = 4,
    parameter int MEM_ADDR_WIDTH  = $clog2(NUM_MEM_BYTES / CACHE_LINE_SIZE)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [MEM_ADDR_WIDTH-1:0]    req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
    output logic                         busy
);

    localparam int          LW        = CACHE_LINE_SIZE * 8;
    localparam int unsigned NUM_LINES = NUM_MEM_BYTES / CACHE_LINE_SIZE;
    localparam logic [7:0]  CNT_LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [7:0]                r_cnt;
    logic                      r_write;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]             r_wdata;
    logic [LW-1:0]             r_rdata;
    logic [LW-1:0]             r_mem [NUM_LINES];
    logic                      w_accept;
    logic                      w_commit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode only the registered state, so no req_* input reaches them.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_commit     = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Reset clears the whole array, which also drops any write still in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_commit) begin
                if (r_write) begin
                    r_mem[r_addr] <= r_wdata;
                end else begin
                    r_rdata <= r_mem[r_addr];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;

endmodule
